// File: rtl/shift_sweep_pkg.sv
// Shared types and constants for the shift sweep sequencer.
package shift_sweep_pkg;

  localparam int DATA_W      = 8;
  localparam int MAG_W       = $clog2(DATA_W);
  localparam int STALL_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_sweep_out_reg.sv
// Valid/ready result register: holds one captured shifter result with its
// magnitude and last flag, and reports when it can take a new one.
module shift_sweep_out_reg
  import shift_sweep_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int MW = MAG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] ld_data,
  input  logic [MW-1:0] ld_mag,
  input  logic          ld_last,
  input  logic          res_ready,
  output logic          slot_free,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [MW-1:0] res_mag,
  output logic          res_last
);

  // Slot is free when empty or when the held result leaves this cycle.
  assign slot_free = !res_valid || res_ready;

  // Capture on load; otherwise drain valid on consumer accept, payload holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_mag   <= '0;
      res_last  <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_data  <= ld_data;
      res_mag   <= ld_mag;
      res_last  <= ld_last;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_sweep_ctrl.sv
// Sweep command sequencer for an external combinational barrel shifter.
// Drives one shift magnitude per cycle and captures each shifter result.
// Optional macro SHIFT_SWEEP_STALL_CNT_EN adds a saturating count of
// cycles a result sat unaccepted (res_valid && !res_ready).
module shift_sweep_ctrl
  import shift_sweep_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [MAG_W-1:0]  cmd_start,
  input  logic [MAG_W-1:0]  cmd_count,
  output logic [DATA_W-1:0] shft_data_in,
  output logic [MAG_W-1:0]  shft_mag,
  input  logic [DATA_W-1:0] shft_data_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [MAG_W-1:0]  res_mag,
  output logic              res_last
`ifdef SHIFT_SWEEP_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  state_t           state;
  logic [MAG_W-1:0] step;
  logic [MAG_W-1:0] count;
  logic             slot_free;
  logic             load;
  logic             at_last;

  assign cmd_ready = (state == IDLE);
  assign at_last   = (step == count);
  assign load      = (state == RUN) && slot_free;

  // Sweep FSM: latch the command, then advance magnitude on each capture.
  // Magnitude wraps naturally at 2^MAG_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      step         <= '0;
      count        <= '0;
      shft_data_in <= '0;
      shft_mag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            shft_data_in <= cmd_data;
            shft_mag     <= cmd_start;
            step         <= '0;
            count        <= cmd_count;
            state        <= RUN;
          end
        end
        RUN: begin
          if (slot_free) begin
            if (at_last) begin
              state <= IDLE;
            end else begin
              step     <= step + 1'b1;
              shft_mag <= shft_mag + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  shift_sweep_out_reg #(.DW(DATA_W), .MW(MAG_W)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .ld_data   (shft_data_out),
    .ld_mag    (shft_mag),
    .ld_last   (at_last),
    .res_ready (res_ready),
    .slot_free (slot_free),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_mag   (res_mag),
    .res_last  (res_last)
  );

`ifdef SHIFT_SWEEP_STALL_CNT_EN
  // Count backpressured cycles, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (res_valid && !res_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// Directed bench for shift_sweep_ctrl with a rotate-left shifter alongside.
module tb_shift_sweep_ctrl;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_data;
  logic [2:0] cmd_start, cmd_count;
  logic [7:0] shft_data_in, shft_data_out;
  logic [2:0] shft_mag;
  logic       res_valid, res_ready, res_last;
  logic [7:0] res_data;
  logic [2:0] res_mag;
`ifdef SHIFT_SWEEP_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  typedef struct {
    logic [7:0] d;
    logic [2:0] m;
    logic       l;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [2:0] c;
    int         first;
    int         stall;
  } cmd_t;

  exp_t exp_tab[14];
  cmd_t cmd_tab[4];
  int   n_vec, n_err, n_acc;

  function automatic logic [7:0] rol(input logic [7:0] d, input logic [2:0] m);
    logic [15:0] t;
    t = {d, d} << m;
    return t[15:8];
  endfunction

  assign shft_data_out = rol(shft_data_in, shft_mag);

  shift_sweep_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .cmd_start     (cmd_start),
    .cmd_count     (cmd_count),
    .shft_data_in  (shft_data_in),
    .shft_mag      (shft_mag),
    .shft_data_out (shft_data_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_mag       (res_mag),
    .res_last      (res_last)
`ifdef SHIFT_SWEEP_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a command at the current negedge; it is taken at the next posedge.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_start = s;
    cmd_count = c;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("first_latency", 32'(res_valid), 32'd0);
  endtask

  // Consume n results starting at exp_tab[first]; stall cycles after result 0.
  task automatic collect(input int first, input int n, input int stall, output int cycles);
    int idx, stalled;
    idx = 0; stalled = 0; cycles = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      res_ready = !(idx == 1 && stalled < stall);
      chk("cmd_ready_run", 32'(cmd_ready), 32'(res_valid && res_last));
      if (cmd_valid && cmd_ready) n_acc++;
      if (res_valid && res_ready) begin
        chk("res_data", 32'(res_data), 32'(exp_tab[first+idx].d));
        chk("res_mag",  32'(res_mag),  32'(exp_tab[first+idx].m));
        chk("res_last", 32'(res_last), 32'(exp_tab[first+idx].l));
        idx++;
        if (idx == n) begin
          cycles = cyc + 1;
          break;
        end
      end else if (res_valid) begin
        stalled++;
        chk("hold_data", 32'(res_data), 32'(exp_tab[first+idx].d));
        chk("hold_mag",  32'(res_mag),  32'(exp_tab[first+idx].m));
        if (idx + 1 < n) chk("hold_shft_mag", 32'(shft_mag), 32'(exp_tab[first+idx+1].m));
      end
    end
    if (cycles < 0) chk("collect_timeout", 32'(idx), 32'(n));
    res_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    n_vec = 0; n_err = 0; n_acc = 0;
    exp_tab[0]  = '{8'hA5, 3'd0, 1'b0};
    exp_tab[1]  = '{8'h4B, 3'd1, 1'b0};
    exp_tab[2]  = '{8'h96, 3'd2, 1'b0};
    exp_tab[3]  = '{8'h2D, 3'd3, 1'b0};
    exp_tab[4]  = '{8'h5A, 3'd4, 1'b0};
    exp_tab[5]  = '{8'hB4, 3'd5, 1'b0};
    exp_tab[6]  = '{8'h69, 3'd6, 1'b0};
    exp_tab[7]  = '{8'hD2, 3'd7, 1'b1};
    exp_tab[8]  = '{8'h60, 3'd6, 1'b0};
    exp_tab[9]  = '{8'hC0, 3'd7, 1'b0};
    exp_tab[10] = '{8'h81, 3'd0, 1'b0};
    exp_tab[11] = '{8'h03, 3'd1, 1'b1};
    exp_tab[12] = '{8'h20, 3'd5, 1'b1};
    exp_tab[13] = '{8'h3C, 3'd2, 1'b1};
    cmd_tab[0] = '{8'hA5, 3'd0, 3'd7, 0,  0};
    cmd_tab[1] = '{8'h81, 3'd6, 3'd3, 8,  0};
    cmd_tab[2] = '{8'hA5, 3'd0, 3'd7, 0,  3};
    cmd_tab[3] = '{8'h01, 3'd5, 3'd0, 12, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_start = '0; cmd_count = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_mag",   32'(res_mag),   32'd0);
    chk("rst_res_last",  32'(res_last),  32'd0);
    chk("rst_shft_data", 32'(shft_data_in), 32'd0);
    chk("rst_shft_mag",  32'(shft_mag),  32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef SHIFT_SWEEP_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven sweeps: full, wrap, backpressured full, single step.
    for (int i = 0; i < 4; i++) begin
      send(cmd_tab[i].d, cmd_tab[i].s, cmd_tab[i].c);
      collect(cmd_tab[i].first, int'(cmd_tab[i].c) + 1, cmd_tab[i].stall, cyc);
      chk("sweep_cycles", 32'(cyc), 32'(int'(cmd_tab[i].c) + 1 + cmd_tab[i].stall));
      @(negedge clk);
      chk("gap_res_valid", 32'(res_valid), 32'd0);
      chk("gap_cmd_ready", 32'(cmd_ready), 32'd1);
    end
`ifdef SHIFT_SWEEP_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // Second command held during a busy sweep is taken exactly once.
    cmd_valid = 1'b1; cmd_data = 8'hA5; cmd_start = 3'd0; cmd_count = 3'd7;
    chk("busy_ready0", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_data = 8'h01; cmd_start = 3'd5; cmd_count = 3'd0;
    chk("busy_ready_run", 32'(cmd_ready), 32'd0);
    n_acc = 0;
    collect(0, 8, 0, cyc);
    chk("busy_cycles", 32'(cyc), 32'd8);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_accepts", 32'(n_acc), 32'd1);
    chk("busy_second_run", 32'(cmd_ready), 32'd0);
    chk("busy_gap", 32'(res_valid), 32'd0);
    collect(12, 1, 0, cyc);
    chk("busy_second_cycles", 32'(cyc), 32'd1);
    @(negedge clk);
    chk("busy_idle", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a sweep.
    send(8'hA5, 3'd0, 3'd7);
    collect(0, 3, 0, cyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_res_data",  32'(res_data),  32'd0);
    chk("mid_rst_res_mag",   32'(res_mag),   32'd0);
    chk("mid_rst_res_last",  32'(res_last),  32'd0);
    chk("mid_rst_shft_data", 32'(shft_data_in), 32'd0);
    chk("mid_rst_shft_mag",  32'(shft_mag),  32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    send(8'h0F, 3'd2, 3'd0);
    collect(13, 1, 0, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd1);
    @(negedge clk);
    chk("post_rst_gap", 32'(res_valid), 32'd0);
    chk("post_rst_idle", 32'(cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
